// File: rtl/mont_const_server.sv
// mont_const_server: holds the k and n_squared block tables and serves them to
// several consumers, each with its own independent k and n_squared read pointer.
module mont_const_server #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096,
  parameter int NUM_CONSUMERS = 3
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   load_start_in,
  input  logic                                   load_valid_in,
  input  logic                                   load_sel_in,
  input  logic [REGISTER_SIZE-1:0]               load_data_in,
  output logic                                   ready_out,
  input  logic [NUM_CONSUMERS-1:0]               k_consumed_in,
  input  logic [NUM_CONSUMERS-1:0]               nsq_consumed_in,
  input  logic [NUM_CONSUMERS-1:0]               restart_in,
  output logic [NUM_CONSUMERS*REGISTER_SIZE-1:0] k_block_out,
  output logic [NUM_CONSUMERS*REGISTER_SIZE-1:0] nsq_block_out,
  output logic [NUM_CONSUMERS-1:0]               k_last_out,
  output logic [NUM_CONSUMERS-1:0]               nsq_last_out,
  output logic                                   error_out
);
  localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int PW = NUM_BLOCKS > 1 ? $clog2(NUM_BLOCKS) : 1;
  localparam int CW = $clog2(NUM_BLOCKS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_BLOCKS);
  localparam logic [PW-1:0] LASTP = PW'(NUM_BLOCKS - 1);
  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] kcnt_q, kcnt_d, ncnt_q, ncnt_d;
  logic [PW-1:0] kptr_q [NUM_CONSUMERS];
  logic [PW-1:0] kptr_d [NUM_CONSUMERS];
  logic [PW-1:0] nptr_q [NUM_CONSUMERS];
  logic [PW-1:0] nptr_d [NUM_CONSUMERS];
  logic err_q, err_d, k_we, n_we;
  logic [REGISTER_SIZE-1:0] k_mem [NUM_BLOCKS];
  logic [REGISTER_SIZE-1:0] n_mem [NUM_BLOCKS];
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    ncnt_d  = ncnt_q;
    kptr_d  = kptr_q;
    nptr_d  = nptr_q;
    err_d   = err_q;
    k_we    = 1'b0;
    n_we    = 1'b0;
    if (state_q != READY && (|k_consumed_in || |nsq_consumed_in)) err_d = 1'b1;
    if (load_start_in) begin
      state_d = LOADING;
      kcnt_d  = '0;
      ncnt_d  = '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        kptr_d[i] = '0;
        nptr_d[i] = '0;
      end
    end else begin
      if (load_valid_in) begin
        if (state_q != LOADING) err_d = 1'b1;
        else if (load_sel_in) begin
          if (ncnt_q == FULL) err_d = 1'b1;
          else begin
            n_we   = 1'b1;
            ncnt_d = ncnt_q + 1'b1;
          end
        end else begin
          if (kcnt_q == FULL) err_d = 1'b1;
          else begin
            k_we   = 1'b1;
            kcnt_d = kcnt_q + 1'b1;
          end
        end
      end
      // ready rises on the same edge that stores the final outstanding word
      if (state_q == LOADING && kcnt_d == FULL && ncnt_d == FULL) state_d = READY;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        if (restart_in[i]) begin
          kptr_d[i] = '0;
          nptr_d[i] = '0;
        end else if (state_q == READY) begin
          if (k_consumed_in[i]) kptr_d[i] = kptr_q[i] == LASTP ? '0 : kptr_q[i] + 1'b1;
          if (nsq_consumed_in[i]) nptr_d[i] = nptr_q[i] == LASTP ? '0 : nptr_q[i] + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= EMPTY;
      kcnt_q  <= '0;
      ncnt_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        kptr_q[i] <= '0;
        nptr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      ncnt_q  <= ncnt_d;
      err_q   <= err_d;
      kptr_q  <= kptr_d;
      nptr_q  <= nptr_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (k_we) k_mem[kcnt_q[PW-1:0]] <= load_data_in;
    if (n_we) n_mem[ncnt_q[PW-1:0]] <= load_data_in;
  end
  for (genvar c = 0; c < NUM_CONSUMERS; c++) begin : g_cons
    assign k_block_out[c*REGISTER_SIZE +: REGISTER_SIZE]   = k_mem[kptr_q[c]];
    assign nsq_block_out[c*REGISTER_SIZE +: REGISTER_SIZE] = n_mem[nptr_q[c]];
    assign k_last_out[c]   = kptr_q[c] == LASTP;
    assign nsq_last_out[c] = nptr_q[c] == LASTP;
  end
  assign ready_out = state_q == READY;
  assign error_out = err_q;
endmodule

// File: tb/tb_mont_const_server.sv
// tb_mont_const_server: directed stimulus against a table/pointer model of the
// constant server, checked every cycle, plus hand-computed literal checks.
module tb_mont_const_server;
  localparam int RS = 32;
  localparam int NB = 128;
  localparam int NC = 3;
  logic clk_in = 1'b0, rst_in = 1'b0;
  logic load_start_in = 1'b0, load_valid_in = 1'b0, load_sel_in = 1'b0;
  logic [RS-1:0] load_data_in = '0;
  logic [NC-1:0] kc = '0, nc = '0, rs = '0;
  logic ready_out, error_out;
  logic [NC*RS-1:0] k_block_out, nsq_block_out;
  logic [NC-1:0] k_last_out, nsq_last_out;
  int tests = 0, fails = 0;
  logic [RS-1:0] mk [NB];
  logic [RS-1:0] mn [NB];
  int mkc, mnc, mkp [NC], mnp [NC];
  bit mload, mready, merr;

  mont_const_server dut (
    .clk_in(clk_in), .rst_in(rst_in), .load_start_in(load_start_in),
    .load_valid_in(load_valid_in), .load_sel_in(load_sel_in), .load_data_in(load_data_in),
    .ready_out(ready_out), .k_consumed_in(kc), .nsq_consumed_in(nc), .restart_in(rs),
    .k_block_out(k_block_out), .nsq_block_out(nsq_block_out),
    .k_last_out(k_last_out), .nsq_last_out(nsq_last_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [RS-1:0] got, input logic [RS-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [RS-1:0] kb(input int i);
    return k_block_out[i*RS +: RS];
  endfunction

  function automatic logic [RS-1:0] nb(input int i);
    return nsq_block_out[i*RS +: RS];
  endfunction

  task automatic mreset();
    mload = 0; mready = 0; merr = 0; mkc = 0; mnc = 0;
    for (int i = 0; i < NC; i++) begin
      mkp[i] = 0;
      mnp[i] = 0;
    end
  endtask

  // model of one clock edge, applied to the inputs currently driven
  task automatic model_step();
    bit was;
    was = mready;
    if (!was && (|kc || |nc)) merr = 1;
    if (load_start_in) begin
      mload = 1; mready = 0; mkc = 0; mnc = 0;
      for (int i = 0; i < NC; i++) begin
        mkp[i] = 0;
        mnp[i] = 0;
      end
    end else begin
      if (load_valid_in) begin
        if (!mload) merr = 1;
        else if (load_sel_in) begin
          if (mnc == NB) merr = 1;
          else begin mn[mnc] = load_data_in; mnc++; end
        end else begin
          if (mkc == NB) merr = 1;
          else begin mk[mkc] = load_data_in; mkc++; end
        end
      end
      if (mload && mkc == NB && mnc == NB) begin
        mload = 0;
        mready = 1;
      end
      for (int i = 0; i < NC; i++) begin
        if (rs[i]) begin
          mkp[i] = 0;
          mnp[i] = 0;
        end else if (was) begin
          if (kc[i]) mkp[i] = (mkp[i] + 1) % NB;
          if (nc[i]) mnp[i] = (mnp[i] + 1) % NB;
        end
      end
    end
  endtask

  task automatic cmp_all();
    chk("ready", ready_out, mready);
    chk("error", error_out, merr);
    for (int i = 0; i < NC; i++) begin
      chk("k_last", k_last_out[i], mkp[i] == NB - 1);
      chk("nsq_last", nsq_last_out[i], mnp[i] == NB - 1);
      if (mready) begin
        chk("k_block", kb(i), mk[mkp[i]]);
        chk("nsq_block", nb(i), mn[mnp[i]]);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    cmp_all();
  endtask

  task automatic load_word(input logic sel, input logic [RS-1:0] d);
    load_valid_in = 1'b1;
    load_sel_in = sel;
    load_data_in = d;
    tick();
    load_valid_in = 1'b0;
  endtask

  task automatic start_load();
    load_start_in = 1'b1;
    tick();
    load_start_in = 1'b0;
  endtask

  // called just after tick(): asserts reset between edges and releases it before the next edge
  task automatic async_reset();
    #2 rst_in = 1'b0;
    #1 mreset();
    chk("rst_ready", ready_out, 0);
    chk("rst_error", error_out, 0);
    cmp_all();
    #2 rst_in = 1'b1;
  endtask

  initial begin
    int lastc;
    mreset();
    #3;
    chk("init_ready", ready_out, 0);
    chk("init_error", error_out, 0);
    chk("init_last", {29'd0, k_last_out}, 0);
    cmp_all();
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    start_load();
    for (int i = 0; i < NB; i++) begin
      load_word(1'b0, RS'(i));
      if (i == NB - 1) chk("ready_before_last", ready_out, 0);
      load_word(1'b1, RS'(1000 + i));
    end
    chk("ready_after_last", ready_out, 1);
    for (int i = 0; i < NC; i++) begin
      chk("k_first", kb(i), 0);
      chk("nsq_first", nb(i), 1000);
    end
    lastc = 0;
    kc = 3'b001;
    for (int j = 0; j < 130; j++) begin
      tick();
      if (k_last_out[0]) lastc++;
    end
    kc = '0;
    chk("k_last_cycles", lastc, 1);
    chk("k0_after_130", kb(0), 2);
    chk("nsq0_unchanged", nb(0), 1000);
    chk("k1_unchanged", kb(1), 0);
    chk("k2_unchanged", kb(2), 0);
    kc = 3'b110;
    repeat (5) tick();
    kc = '0;
    chk("k1_at5", kb(1), 5);
    rs = 3'b010;
    kc = 3'b110;
    tick();
    rs = '0;
    kc = '0;
    chk("k1_restart_wins", kb(1), 0);
    chk("k2_advance", kb(2), 6);
    nc = 3'b101;
    repeat (3) tick();
    nc = '0;
    chk("nsq0_at3", nb(0), 1003);
    chk("k2_indep", kb(2), 6);
    start_load();
    for (int i = 0; i < NB; i++) load_word(1'b0, RS'(500 + i));
    chk("err_before_overflow", error_out, 0);
    load_word(1'b0, RS'(999));
    chk("err_overflow", error_out, 1);
    rs = 3'b111;
    for (int i = 0; i < NB; i++) begin
      load_word(1'b1, RS'(2000 + i));
      rs = '0;
    end
    chk("ready_after_overflow", ready_out, 1);
    chk("k_after_overflow", kb(1), 500);
    chk("nsq_after_overflow", nb(2), 2000);
    start_load();
    for (int i = 0; i < NB; i++) begin
      load_word(1'b0, RS'(i));
      load_word(1'b1, RS'(i));
    end
    chk("err_sticky_reload", error_out, 1);
    async_reset();
    kc = 3'b100;
    tick();
    kc = '0;
    chk("err_consume_not_ready", error_out, 1);
    chk("k_ignored_not_ready", {29'd0, k_last_out}, 0);
    async_reset();
    start_load();
    for (int i = 0; i < 25; i++) begin
      load_word(1'b0, RS'(7));
      load_word(1'b1, RS'(8));
    end
    async_reset();
    repeat (3) tick();
    chk("ready_stays_low", ready_out, 0);
    start_load();
    for (int i = 0; i < NB; i++) begin
      load_word(1'b1, 32'h0F000000 + RS'(3 * i));
      load_word(1'b0, 32'hA5A50000 + RS'(i));
    end
    chk("reload_ready", ready_out, 1);
    chk("reload_k0", kb(0), 32'hA5A50000);
    chk("reload_nsq0", nb(0), 32'h0F000000);
    chk("reload_err", error_out, 0);
    kc = 3'b010;
    nc = 3'b010;
    for (int j = 0; j < NB; j++) begin
      tick();
      if (j == 9) chk("reload_k1_10", kb(1), 32'hA5A5000A);
      if (j == 9) chk("reload_nsq1_10", nb(1), 32'h0F00001E);
    end
    kc = '0;
    nc = '0;
    chk("reload_wrap", kb(1), 32'hA5A50000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
